// File: rtl/zbuffer_writer.sv
// zbuffer_writer: depth-tested pixel writer with a 3-stage read/compare
// pipeline, write forwarding, and a full depth/framebuffer clear engine.
module zbuffer_writer #(
  parameter int unsigned             FB_HRES     = 320,
  parameter int unsigned             FB_VRES     = 180,
  parameter int unsigned             ZWIDTH      = 16,
  parameter int unsigned             COLOR_WIDTH = 16,
  parameter logic [COLOR_WIDTH-1:0]  CLEAR_COLOR = '0,
  localparam int unsigned            ADDR_WIDTH  = $clog2(FB_HRES * FB_VRES),
  localparam int unsigned            HWIDTH      = $clog2(FB_HRES),
  localparam int unsigned            VWIDTH      = $clog2(FB_VRES)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic [HWIDTH-1:0]        hcount_in,
  input  logic [VWIDTH-1:0]        vcount_in,
  input  logic signed [ZWIDTH-1:0] z_in,
  input  logic [COLOR_WIDTH-1:0]   color_in,
  input  logic                     clear_in,
  output logic                     clear_done_out,
  output logic [ADDR_WIDTH-1:0]    depth_raddr_out,
  input  logic [ZWIDTH-1:0]        depth_rdata_in,
  output logic                     depth_we_out,
  output logic [ADDR_WIDTH-1:0]    depth_waddr_out,
  output logic [ZWIDTH-1:0]        depth_wdata_out,
  output logic                     fb_we_out,
  output logic [ADDR_WIDTH-1:0]    fb_addr_out,
  output logic [COLOR_WIDTH-1:0]   fb_color_out
);

  localparam int unsigned       NPIX      = FB_HRES * FB_VRES;
  localparam int unsigned       CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [ZWIDTH-1:0] Z_FAR     = {1'b0, {(ZWIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic                   vld;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [ZWIDTH-1:0]      z;
    logic [COLOR_WIDTH-1:0] color;
  } pix_t;

  typedef struct packed {
    logic                   we;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [ZWIDTH-1:0]      z;
    logic [COLOR_WIDTH-1:0] color;
  } wr_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ZWIDTH-1:0]     z;
  } hist_t;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  clr_q, clr_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  wr_t                   wr_q, wr_d;
  pix_t                  s1_q, s1_d, s2_q, s3_q;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  hist_t                 hist1_q, hist1_d, hist2_q;

  logic                  in_range_c;
  logic [ADDR_WIDTH-1:0] pix_addr_c;
  logic [ZWIDTH-1:0]     eff_z_c;
  logic                  pass_c;
  logic                  in_flight_c;

  // Input stage: address generation, range check and read-address capture.
  always_comb begin
    in_range_c = (32'(hcount_in) < FB_HRES) && (32'(vcount_in) < FB_VRES);
    pix_addr_c = ADDR_WIDTH'(vcount_in) * ADDR_WIDTH'(FB_HRES) + ADDR_WIDTH'(hcount_in);
    s1_d       = '0;
    s1_d.vld   = valid_in && ready_q && in_range_c;
    s1_d.addr  = pix_addr_c;
    s1_d.z     = z_in;
    s1_d.color = color_in;
    raddr_d    = s1_d.vld ? pix_addr_c : raddr_q;
    hist1_d    = '{we: wr_q.we, addr: wr_q.addr, z: wr_q.z};
  end

  // Effective stored depth: memory data overridden by the newest in-flight write.
  always_comb begin
    eff_z_c = depth_rdata_in;
    if (hist2_q.we && (hist2_q.addr == s3_q.addr)) eff_z_c = hist2_q.z;
    if (hist1_q.we && (hist1_q.addr == s3_q.addr)) eff_z_c = hist1_q.z;
    if (wr_q.we && (wr_q.addr == s3_q.addr))       eff_z_c = wr_q.z;
    pass_c      = s3_q.vld && ($signed(s3_q.z) < $signed(eff_z_c));
    in_flight_c = s1_q.vld || s2_q.vld || s3_q.vld;
  end

  // Pipeline registers and write history used for forwarding.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      raddr_q <= '0;
      hist1_q <= '0;
      hist2_q <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      raddr_q <= raddr_d;
      hist1_q <= hist1_d;
      hist2_q <= hist1_q;
    end
  end

  // Next-state and write-port selection: clear sweep or depth-test result.
  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    done_d      = 1'b0;
    wr_d.we     = pass_c;
    wr_d.addr   = s3_q.addr;
    wr_d.z      = s3_q.z;
    wr_d.color  = s3_q.color;
    unique case (state_q)
      ST_CLEAR: begin
        if (clr_q == CNT_WIDTH'(NPIX)) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
          clr_d   = '0;
        end else begin
          wr_d.we    = 1'b1;
          wr_d.addr  = clr_q[ADDR_WIDTH-1:0];
          wr_d.z     = Z_FAR;
          wr_d.color = CLEAR_COLOR;
          clr_d      = clr_q + CNT_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (clear_in) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!in_flight_c) state_d = ST_CLEAR;
      end
      default: state_d = ST_CLEAR;
    endcase
    ready_d = (state_d == ST_RUN);
  end

  // State, clear counter and registered outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_CLEAR;
      clr_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
    end
  end

  assign ready_out       = ready_q;
  assign clear_done_out  = done_q;
  assign depth_raddr_out = raddr_q;
  assign depth_we_out    = wr_q.we;
  assign depth_waddr_out = wr_q.addr;
  assign depth_wdata_out = wr_q.z;
  assign fb_we_out       = wr_q.we;
  assign fb_addr_out     = wr_q.addr;
  assign fb_color_out    = wr_q.color;

endmodule
